// File: rtl/video_frame_monitor_pkg.sv
// rtl/video_frame_monitor_pkg.sv - shared types, CRC-32 constants and CRC step function
package video_frame_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } vfm_state_e;

  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

  // Advance a CRC-32 (MSB first, no reflection) over the low 'width' bits of 'data',
  // starting from bit width-1. Words wider than 64 bits are not supported.
  function automatic logic [31:0] crc32_next(input logic [31:0] crc_in,
                                             input logic [63:0] data,
                                             input int          width);
    logic [31:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 63; i >= 0; i--) begin
      if (i < width) begin
        fb = c[31] ^ data[i];
        c  = {c[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/video_frame_monitor_crc.sv
// rtl/video_frame_monitor_crc.sv - per-frame CRC-32 accumulator with end-of-frame latch
module video_frame_monitor_crc
  import video_frame_monitor_pkg::*;
#(
  parameter int C_DATA_WIDTH = 24
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    clear_i,   // start of the first measured frame
  input  logic                    acc_i,     // active pixel inside a measured frame
  input  logic                    latch_i,   // end of a measured frame
  input  logic [C_DATA_WIDTH-1:0] data_i,
  output logic [31:0]             crc_o
);

  logic [31:0] acc_q, acc_d;
  logic [31:0] crc_q, crc_d;
  logic [63:0] data_ext;

  assign data_ext = 64'(data_i);
  assign crc_o    = crc_q;

  // Accumulate pixels; at frame end publish the running value and restart from the seed.
  always_comb begin
    acc_d = acc_q;
    crc_d = crc_q;
    if (latch_i) begin
      crc_d = acc_q;
      acc_d = CRC32_INIT;
    end else if (clear_i) begin
      acc_d = CRC32_INIT;
    end else if (acc_i) begin
      acc_d = crc32_next(acc_q, data_ext, C_DATA_WIDTH);
    end
  end

  // Accumulator and published CRC registers.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      acc_q <= CRC32_INIT;
      crc_q <= 32'h0;
    end else begin
      acc_q <= acc_d;
      crc_q <= crc_d;
    end
  end

endmodule

// File: rtl/video_frame_monitor.sv
// rtl/video_frame_monitor.sv - pixel-bus frame counter and geometry monitor; optional CRC via VIDEO_FRAME_MONITOR_CRC_EN
module video_frame_monitor
  import video_frame_monitor_pkg::*;
#(
  parameter int C_DATA_WIDTH        = 24,
  parameter int C_COORD_WIDTH       = 12,
  parameter int C_FRAME_CNT_WIDTH   = 8,
  parameter int C_VSYNC_ACTIVE_HIGH = 1
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         ENABLE,
  input  logic [C_FRAME_CNT_WIDTH-1:0] FRAME_TARGET,
  input  logic                         DE,
  input  logic                         HSYNC,
  input  logic                         VSYNC,
  input  logic [C_DATA_WIDTH-1:0]      DATA,
  output logic                         BUSY,
  output logic                         INTR,
  output logic [C_FRAME_CNT_WIDTH-1:0] FRAME_COUNT,
  output logic [C_COORD_WIDTH-1:0]     H_ACTIVE,
  output logic [C_COORD_WIDTH-1:0]     V_ACTIVE,
  output logic                         GEOM_ERR
`ifdef VIDEO_FRAME_MONITOR_CRC_EN
  ,
  output logic [31:0]                  FRAME_CRC
`endif
);

  localparam logic                     VS_POL    = (C_VSYNC_ACTIVE_HIGH != 0);
  localparam logic [C_COORD_WIDTH-1:0] COORD_MAX = {C_COORD_WIDTH{1'b1}};

  vfm_state_e state_q, state_d;
  logic       busy_q, busy_d;
  logic       intr_q, intr_d;

  logic prev_vs_act_q, prev_de_q;

  logic [C_COORD_WIDTH-1:0]     pix_cnt_q, pix_cnt_d;
  logic [C_COORD_WIDTH-1:0]     line_cnt_q, line_cnt_d;
  logic [C_COORD_WIDTH-1:0]     ref_w_q, ref_w_d;
  logic                         line_err_q, line_err_d;
  logic [C_FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic [C_COORD_WIDTH-1:0]     h_active_q, h_active_d;
  logic [C_COORD_WIDTH-1:0]     v_active_q, v_active_d;
  logic                         geom_err_q, geom_err_d;

  logic                         vs_act, eof, line_end;
  logic                         measure_go, sync_eof;
  logic [C_COORD_WIDTH-1:0]     lines_fin, ref_fin, line_cnt_inc, pix_cnt_inc;
  logic                         err_fin;
  logic [C_FRAME_CNT_WIDTH-1:0] frame_cnt_inc;
  logic                         target_hit;

  // HSYNC is carried on the bus but not measured; DATA only feeds the optional CRC.
  logic unused_inputs;
  assign unused_inputs = ^{HSYNC, DATA};

  assign vs_act   = ~(VSYNC ^ VS_POL);
  assign eof      = prev_vs_act_q & ~vs_act;
  assign line_end = prev_de_q & ~DE;

  assign measure_go = (state_q == MEASURE) && ENABLE;
  assign sync_eof   = (state_q == SYNC) && ENABLE && eof;

  assign line_cnt_inc = (line_cnt_q == COORD_MAX) ? line_cnt_q : line_cnt_q + C_COORD_WIDTH'(1);
  assign pix_cnt_inc  = (pix_cnt_q == COORD_MAX) ? pix_cnt_q : pix_cnt_q + C_COORD_WIDTH'(1);

  // Frame totals with a line ending on this same edge folded in, so it lands in the closing frame.
  assign lines_fin = line_end ? line_cnt_inc : line_cnt_q;
  assign ref_fin   = (line_end && (line_cnt_q == '0)) ? pix_cnt_q : ref_w_q;
  assign err_fin   = line_err_q |
                     (line_end && (line_cnt_q != '0) && (pix_cnt_q != ref_w_q));

  assign frame_cnt_inc = frame_cnt_q + C_FRAME_CNT_WIDTH'(1);
  assign target_hit    = (FRAME_TARGET != '0) && (frame_cnt_inc == FRAME_TARGET);

  // Next-state logic: ENABLE low always returns to IDLE; target hit ends measuring with one INTR.
  always_comb begin
    state_d = state_q;
    intr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ENABLE) state_d = SYNC;
      end
      SYNC: begin
        if (!ENABLE)  state_d = IDLE;
        else if (eof) state_d = MEASURE;
      end
      MEASURE: begin
        if (!ENABLE) begin
          state_d = IDLE;
        end else if (eof && target_hit) begin
          state_d = DONE;
          intr_d  = 1'b1;
        end
      end
      DONE: begin
        if (!ENABLE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SYNC) || (state_d == MEASURE);
  end

  // State, BUSY and INTR registers.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      intr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      intr_q  <= intr_d;
    end
  end

  // Measurement datapath: per-line width tracking, per-frame latch of geometry and frame count.
  always_comb begin
    pix_cnt_d   = pix_cnt_q;
    line_cnt_d  = line_cnt_q;
    ref_w_d     = ref_w_q;
    line_err_d  = line_err_q;
    frame_cnt_d = frame_cnt_q;
    h_active_d  = h_active_q;
    v_active_d  = v_active_q;
    geom_err_d  = geom_err_q;
    if (sync_eof) begin
      pix_cnt_d   = '0;
      line_cnt_d  = '0;
      ref_w_d     = '0;
      line_err_d  = 1'b0;
      frame_cnt_d = '0;
    end else if (measure_go) begin
      if (eof) begin
        h_active_d  = ref_fin;
        v_active_d  = lines_fin;
        geom_err_d  = err_fin;
        frame_cnt_d = frame_cnt_inc;
        pix_cnt_d   = '0;
        line_cnt_d  = '0;
        ref_w_d     = '0;
        line_err_d  = 1'b0;
      end else if (line_end) begin
        line_cnt_d = line_cnt_inc;
        if (line_cnt_q == '0) begin
          ref_w_d = pix_cnt_q;
        end else if (pix_cnt_q != ref_w_q) begin
          line_err_d = 1'b1;
        end
        pix_cnt_d = '0;
      end else if (DE) begin
        pix_cnt_d = pix_cnt_inc;
      end
    end
  end

  // Datapath registers plus the edge-detect history of VSYNC and DE.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      prev_vs_act_q <= 1'b0;
      prev_de_q     <= 1'b0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      ref_w_q       <= '0;
      line_err_q    <= 1'b0;
      frame_cnt_q   <= '0;
      h_active_q    <= '0;
      v_active_q    <= '0;
      geom_err_q    <= 1'b0;
    end else begin
      prev_vs_act_q <= vs_act;
      prev_de_q     <= DE;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      ref_w_q       <= ref_w_d;
      line_err_q    <= line_err_d;
      frame_cnt_q   <= frame_cnt_d;
      h_active_q    <= h_active_d;
      v_active_q    <= v_active_d;
      geom_err_q    <= geom_err_d;
    end
  end

  assign BUSY        = busy_q;
  assign INTR        = intr_q;
  assign FRAME_COUNT = frame_cnt_q;
  assign H_ACTIVE    = h_active_q;
  assign V_ACTIVE    = v_active_q;
  assign GEOM_ERR    = geom_err_q;

`ifdef VIDEO_FRAME_MONITOR_CRC_EN
  video_frame_monitor_crc #(
    .C_DATA_WIDTH(C_DATA_WIDTH)
  ) u_crc (
    .CLK    (CLK),
    .nRST   (nRST),
    .clear_i(sync_eof),
    .acc_i  (measure_go && DE && !eof),
    .latch_i(measure_go && eof),
    .data_i (DATA),
    .crc_o  (FRAME_CRC)
  );
`endif

endmodule

// File: tb/tb_video_frame_monitor.sv
// tb/tb_video_frame_monitor.sv - self-checking bench for video_frame_monitor (both VSYNC polarities)
module tb_video_frame_monitor;

  localparam int DW = 24;
  localparam int CW = 12;
  localparam int FW = 8;

  logic          clk = 1'b0;
  logic          rst_n_r, enable_r, de_r, hs_r, vs_r, vs_n;
  logic [FW-1:0] target_r;
  logic [DW-1:0] data_r;

  logic          busy_o [2];
  logic          intr_o [2];
  logic [FW-1:0] fc_o   [2];
  logic [CW-1:0] h_o    [2];
  logic [CW-1:0] v_o    [2];
  logic          err_o  [2];
`ifdef VIDEO_FRAME_MONITOR_CRC_EN
  logic [31:0]   crc_o  [2];
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign vs_n = ~vs_r;

  video_frame_monitor #(.C_DATA_WIDTH(DW), .C_COORD_WIDTH(CW), .C_FRAME_CNT_WIDTH(FW),
                        .C_VSYNC_ACTIVE_HIGH(1)) dut_hi (
    .CLK(clk), .nRST(rst_n_r), .ENABLE(enable_r), .FRAME_TARGET(target_r),
    .DE(de_r), .HSYNC(hs_r), .VSYNC(vs_r), .DATA(data_r),
    .BUSY(busy_o[0]), .INTR(intr_o[0]), .FRAME_COUNT(fc_o[0]),
    .H_ACTIVE(h_o[0]), .V_ACTIVE(v_o[0]), .GEOM_ERR(err_o[0])
`ifdef VIDEO_FRAME_MONITOR_CRC_EN
    , .FRAME_CRC(crc_o[0])
`endif
  );

  video_frame_monitor #(.C_DATA_WIDTH(DW), .C_COORD_WIDTH(CW), .C_FRAME_CNT_WIDTH(FW),
                        .C_VSYNC_ACTIVE_HIGH(0)) dut_lo (
    .CLK(clk), .nRST(rst_n_r), .ENABLE(enable_r), .FRAME_TARGET(target_r),
    .DE(de_r), .HSYNC(hs_r), .VSYNC(vs_n), .DATA(data_r),
    .BUSY(busy_o[1]), .INTR(intr_o[1]), .FRAME_COUNT(fc_o[1]),
    .H_ACTIVE(h_o[1]), .V_ACTIVE(v_o[1]), .GEOM_ERR(err_o[1])
`ifdef VIDEO_FRAME_MONITOR_CRC_EN
    , .FRAME_CRC(crc_o[1])
`endif
  );

  // Frame-level reference model: phase 0 idle, 1 waiting for first EOF, 2 measuring, 3 done.
  int m_phase, m_fc, m_h, m_v, m_err, m_intr;
  int lw[$];

  typedef struct {
    int target; int nl; int w0; int w1; int w2;
    int e_fc; int e_h; int e_v; int e_err; int e_intr; int e_busy;
  } row_t;
  row_t rows [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_exp(input string tag, input int e_busy, input int e_intr, input int e_fc,
                           input int e_h, input int e_v, input int e_err);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s[%0d].busy", tag, k), 64'(busy_o[k]), 64'(e_busy));
      chk($sformatf("%s[%0d].intr", tag, k), 64'(intr_o[k]), 64'(e_intr));
      chk($sformatf("%s[%0d].frame_count", tag, k), 64'(fc_o[k]), 64'(e_fc));
      chk($sformatf("%s[%0d].h_active", tag, k), 64'(h_o[k]), 64'(e_h));
      chk($sformatf("%s[%0d].v_active", tag, k), 64'(v_o[k]), 64'(e_v));
      chk($sformatf("%s[%0d].geom_err", tag, k), 64'(err_o[k]), 64'(e_err));
    end
  endtask

  task automatic model_check(input string tag);
    check_exp(tag, (m_phase == 1 || m_phase == 2) ? 1 : 0, m_intr, m_fc, m_h, m_v, m_err);
  endtask

  task automatic model_eof();
    m_intr = 0;
    if (!enable_r) return;
    if (m_phase == 1) begin
      m_phase = 2;
      m_fc    = 0;
    end else if (m_phase == 2) begin
      m_fc  = (m_fc + 1) % (1 << FW);
      m_v   = lw.size();
      m_h   = (lw.size() > 0) ? lw[0] : 0;
      m_err = 0;
      foreach (lw[i]) if (lw[i] != lw[0]) m_err = 1;
      if (target_r != 0 && m_fc == int'(target_r)) begin
        m_phase = 3;
        m_intr  = 1;
      end
    end
  endtask

  task automatic tick(input logic de, input logic vs, input logic [DW-1:0] d);
    @(negedge clk);
    de_r   = de;
    vs_r   = vs;
    hs_r   = ~de;
    data_r = d;
  endtask

  task automatic set_enable(input logic v);
    @(negedge clk);
    enable_r = v;
    m_intr   = 0;
    if (!v) m_phase = 0;
    else if (m_phase == 0) m_phase = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n_r = 1'b0;
    de_r    = 1'b0;
    vs_r    = 1'b0;
    @(negedge clk);
    rst_n_r = 1'b1;
    m_fc = 0; m_h = 0; m_v = 0; m_err = 0; m_intr = 0;
    m_phase = enable_r ? 1 : 0;
  endtask

  // Lines from lw, then a VSYNC pulse; same_edge makes the last line end on the EOF edge.
  // Returns sampled half a cycle after the EOF edge, with the model already advanced.
  task automatic drive_frame(input bit same_edge);
    bit se;
    se = same_edge && (lw.size() > 0);
    for (int l = 0; l < lw.size(); l++) begin
      for (int p = 0; p < lw[l]; p++)
        tick(1'b1, (se && l == lw.size() - 1) ? 1'b1 : 1'b0, DW'($urandom()));
      if (!(se && l == lw.size() - 1)) begin
        tick(1'b0, 1'b0, DW'($urandom()));
        tick(1'b0, 1'b0, DW'($urandom()));
      end
    end
    if (!se) begin
      tick(1'b0, 1'b1, DW'($urandom()));
      tick(1'b0, 1'b1, DW'($urandom()));
    end
    tick(1'b0, 1'b0, DW'($urandom()));
    @(negedge clk);
    model_eof();
  endtask

`ifdef VIDEO_FRAME_MONITOR_CRC_EN
  function automatic logic [31:0] sw_crc48(input logic [47:0] stream);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFFFFFF;
    for (int i = 5; i >= 0; i--) begin
      b = stream[i*8 +: 8];
      c = c ^ {b, 24'h0};
      for (int j = 0; j < 8; j++) c = c[31] ? ({c[30:0], 1'b0} ^ 32'h04C11DB7) : {c[30:0], 1'b0};
    end
    return c;
  endfunction
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nl, base;
    bit se;
    rows[0] = '{3, 3, 4, 4, 4, 1, 4, 3, 0, 0, 1};
    rows[1] = '{3, 3, 4, 4, 5, 2, 4, 3, 1, 0, 1};
    rows[2] = '{9, 2, 6, 6, 0, 3, 6, 2, 0, 0, 1};
    rows[3] = '{4, 0, 0, 0, 0, 4, 0, 0, 0, 1, 0};
    rows[4] = '{4, 2, 2, 2, 0, 4, 0, 0, 0, 0, 0};

    rst_n_r = 1'b0; enable_r = 1'b0; de_r = 1'b0; hs_r = 1'b1; vs_r = 1'b0;
    target_r = '0; data_r = '0;
    m_phase = 0; m_fc = 0; m_h = 0; m_v = 0; m_err = 0; m_intr = 0;
    repeat (3) @(negedge clk);
    check_exp("reset", 0, 0, 0, 0, 0, 0);
    rst_n_r = 1'b1;

    // Basic lifecycle: partial frame discarded, INTR after the 2nd measured frame.
    target_r = 8'd2;
    set_enable(1'b1);
    lw = '{4, 4, 4};
    drive_frame(0); model_check("t1_sync");
    drive_frame(0); model_check("t1_f1");
    drive_frame(0); check_exp("t1_f2", 0, 1, 2, 4, 3, 0);
    tick(1'b0, 1'b0, '0);
    check_exp("t1_after", 0, 0, 2, 4, 3, 0);

    // Table of frames on a fresh run: geometry error, target change, empty frame, DONE hold.
    set_enable(1'b0);
    do_reset();
    target_r = 8'd3;
    set_enable(1'b1);
    lw = '{1};
    drive_frame(0);
    for (int r = 0; r < 5; r++) begin
      target_r = FW'(rows[r].target);
      lw.delete();
      if (rows[r].nl > 0) lw.push_back(rows[r].w0);
      if (rows[r].nl > 1) lw.push_back(rows[r].w1);
      if (rows[r].nl > 2) lw.push_back(rows[r].w2);
      drive_frame(0);
      check_exp($sformatf("row%0d", r), rows[r].e_busy, rows[r].e_intr, rows[r].e_fc,
                rows[r].e_h, rows[r].e_v, rows[r].e_err);
    end

    // Line end coinciding with EOF belongs to the closing frame.
    target_r = 8'd0;
    set_enable(1'b0);
    set_enable(1'b1);
    lw = '{2}; drive_frame(0);
    lw = '{3, 3}; drive_frame(1); model_check("same_edge_ok");
    lw = '{3, 2}; drive_frame(1); model_check("same_edge_err");

    // Abort mid-frame, then restart: frame count starts over after the next EOF.
    target_r = 8'd200;
    lw = '{4}; drive_frame(0); model_check("abort_pre");
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    set_enable(1'b0);
    tick(1'b0, 1'b0, '0);
    model_check("abort_idle");
    set_enable(1'b1);
    tick(1'b0, 1'b0, '0);
    model_check("abort_resync");
    lw = '{4}; drive_frame(0); model_check("abort_sync_eof");
    lw = '{5, 5}; drive_frame(0); model_check("abort_f1");

    // Reset in the middle of a line clears every output on the next edge.
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    @(negedge clk);
    rst_n_r = 1'b0;
    @(negedge clk);
    check_exp("mid_reset", 0, 0, 0, 0, 0, 0);
    rst_n_r = 1'b1;
    de_r = 1'b0;
    m_fc = 0; m_h = 0; m_v = 0; m_err = 0; m_intr = 0; m_phase = 1;

    // Target 0 never fires; 300 frames wrap the 8-bit counter to 44.
    target_r = 8'd0;
    lw = '{1};
    drive_frame(0);
    for (int f = 0; f < 300; f++) begin
      drive_frame(0);
      model_check($sformatf("t0_f%0d", f));
    end
    check_exp("t0_end", 1, 0, 44, 1, 1, 0);

    // Randomised frames and targets against the frame-level model.
    do_reset();
    target_r = FW'($urandom_range(0, 6));
    for (int it = 0; it < 60; it++) begin
      if (m_phase == 3) begin
        set_enable(1'b0);
        set_enable(1'b1);
      end
      if ($urandom_range(0, 7) == 0) target_r = FW'($urandom_range(0, 6));
      nl   = $urandom_range(0, 4);
      base = $urandom_range(1, 6);
      lw.delete();
      for (int l = 0; l < nl; l++)
        lw.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : base);
      se = (nl > 0) && ($urandom_range(0, 3) == 0);
      drive_frame(se);
      model_check($sformatf("rand%0d", it));
    end

`ifdef VIDEO_FRAME_MONITOR_CRC_EN
    // CRC over one 2-pixel line: bytes 00 00 00 FF FF FF.
    set_enable(1'b0);
    do_reset();
    target_r = 8'd0;
    set_enable(1'b1);
    lw = '{1}; drive_frame(0);
    tick(1'b1, 1'b0, 24'h000000);
    tick(1'b1, 1'b0, 24'hFFFFFF);
    tick(1'b0, 1'b0, 24'h123456);
    tick(1'b0, 1'b0, 24'h654321);
    tick(1'b0, 1'b1, 24'h0);
    tick(1'b0, 1'b1, 24'h0);
    tick(1'b0, 1'b0, 24'h0);
    @(negedge clk);
    lw = '{2};
    model_eof();
    model_check("crc_geom");
    for (int k = 0; k < 2; k++)
      chk($sformatf("crc[%0d]", k), 64'(crc_o[k]), 64'(sw_crc48(48'h000000FFFFFF)));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_frame_monitor.md
Name: video_frame_monitor

Overview:
- Parametrised HDMI/DVI output-stream monitor sitting on the pixel bus after hdmi_controller (DE/HSYNC/VSYNC/DATA).
- Detects frame boundaries, counts frames and measures active geometry per frame: pixels per line, lines per frame, line-width consistency.
- Raises a one-cycle interrupt and drops BUSY once a programmable frame count is reached.
- Generalises fixed "end after frame 2, active-high VSYNC, 24-bit" simulation-lifecycle logic into a reusable, polarity- and width-configurable block with a measurement state machine.

Parameters:
- C_DATA_WIDTH, 24, pixel data width in bits (24 or 30/36 for deep colour).
- C_COORD_WIDTH, 12, width of pixel/line counters and geometry outputs.
- C_FRAME_CNT_WIDTH, 8, width of the frame counter and FRAME_TARGET.
- C_VSYNC_ACTIVE_HIGH, 1, 1 = VSYNC active high, 0 = active low.

Ports:
- CLK  in  1  pixel clock; only clock.
- nRST  in  1  synchronous, active-low reset.
- ENABLE  in  1  run monitor; deassert aborts to IDLE.
- FRAME_TARGET  in  C_FRAME_CNT_WIDTH  frame count that fires INTR; 0 = never fire.
- DE  in  1  data enable.
- HSYNC  in  1  horizontal sync (pass-through only, not measured).
- VSYNC  in  1  vertical sync, polarity per C_VSYNC_ACTIVE_HIGH.
- DATA  in  C_DATA_WIDTH  pixel data.
- BUSY  out  1  monitor measuring and target not yet reached.
- INTR  out  1  one-cycle pulse when FRAME_COUNT reaches FRAME_TARGET.
- FRAME_COUNT  out  C_FRAME_CNT_WIDTH  completed frames since entering MEASURE.
- H_ACTIVE  out  C_COORD_WIDTH  width of the first line of the last completed frame.
- V_ACTIVE  out  C_COORD_WIDTH  DE-lines in the last completed frame.
- GEOM_ERR  out  1  last completed frame had unequal line widths.

Behaviour:
- Reset (nRST=0 at a CLK edge): all outputs 0, all counters 0, prev_vsync/prev_de registers = inactive, state = IDLE. Applies mid-frame; no partial results survive.
- vs_act = VSYNC XNOR C_VSYNC_ACTIVE_HIGH.
- EOF event at edge n: prev_vs_act=1 and vs_act=0.
- Line-end event: prev_de=1 and DE=0.
- States:
  - IDLE: ENABLE=1 -> SYNC.
  - SYNC: discard the partial frame; on EOF -> MEASURE, counters cleared.
  - MEASURE: on each EOF, FRAME_COUNT +1; if the new value == FRAME_TARGET (nonzero) -> DONE.
  - DONE: hold all outputs; ENABLE=0 -> IDLE.
  - In any state except IDLE, ENABLE=0 -> IDLE, BUSY=0, outputs hold last values.
- BUSY = 1 exactly in SYNC and MEASURE (registered).
- Pixel counter: +1 per DE=1 cycle in MEASURE, saturating at all-ones. Cleared on line-end (after latch) and on EOF.
- On line-end:
  - line counter +1 (saturating);
  - first line of the frame stores its width as ref_w;
  - later lines set the err flag if width != ref_w.
- On EOF: H_ACTIVE<=ref_w, V_ACTIVE<=line count, GEOM_ERR<=err flag; then per-frame state is cleared. All outputs update at edge n+1.
- Line-end and EOF on the same edge: the line is counted first and included in the frame being closed.
- A frame with zero DE lines gives H_ACTIVE=0, V_ACTIVE=0, GEOM_ERR=0 and still counts.
- INTR: registered, high for exactly the cycle after the EOF that makes FRAME_COUNT==FRAME_TARGET; never re-fires in DONE.
- FRAME_COUNT wraps modulo 2^C_FRAME_CNT_WIDTH; FRAME_TARGET=0 never matches (runs indefinitely).
- FRAME_TARGET is sampled at each EOF, so changing it mid-run is legal.

Optional Feature:
- Macro VIDEO_FRAME_MONITOR_CRC_EN.
- When defined:
  - extra output FRAME_CRC [31:0], reset 0.
  - CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, MSB-first, no reflection, no final XOR) is accumulated over DATA on every DE=1 cycle in MEASURE.
  - FRAME_CRC is latched on EOF together with the geometry outputs; the accumulator is then reinitialised.
- When undefined: port absent, no CRC logic.

Decomposition:
- Package video_frame_monitor_pkg holds:
  - state enum {IDLE, SYNC, MEASURE, DONE};
  - CRC32_POLY and CRC32_INIT constants;
  - a function computing the next CRC for one C_DATA_WIDTH word.
- One natural sub-module: video_frame_monitor_crc (accumulator plus latch), instantiated only under VIDEO_FRAME_MONITOR_CRC_EN.

Test Plan:
- ENABLE=1, FRAME_TARGET=2, three full frames of 4 px x 3 lines, active-high VSYNC -> first partial frame ignored; INTR pulses one cycle after the 2nd measured EOF; FRAME_COUNT=2, H_ACTIVE=4, V_ACTIVE=3, GEOM_ERR=0, BUSY falls with INTR.
- Frame with line widths 4,4,5 -> at EOF+1: GEOM_ERR=1, H_ACTIVE=4, V_ACTIVE=3.
- C_VSYNC_ACTIVE_HIGH=0 with inverted VSYNC and the first stimulus reused -> identical results.
- Drop ENABLE mid-MEASURE, then reassert -> IDLE then SYNC, FRAME_COUNT restarts at 0 after the next EOF, no INTR from the aborted run. nRST=0 mid-frame -> all outputs 0 next edge.
- FRAME_TARGET=0 for 300 frames with C_FRAME_CNT_WIDTH=8 -> INTR never asserts, FRAME_COUNT=44 (wrapped), BUSY=1.
- CRC_EN build: one line of 2 pixels 24'h000000, 24'hFFFFFF -> FRAME_CRC equals software model over bytes 00 00 00 FF FF FF (same poly/init rules).
